// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset request sequencer.
// Provides the FSM state encoding and the counter/grant width derivations.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ASSERT    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Counter must reach both compare values without wrapping.
    function automatic int cnt_width(input int pulse_width, input int timeout);
        return clog2(((pulse_width > timeout) ? pulse_width : timeout) + 1);
    endfunction

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr,
// wrapping around to zero.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the search so no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // Walk from the farthest offset down so the nearest hit is the one that sticks.
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j[W-1:0]]) begin
                valid = 1'b1;
                idx   = j[W-1:0];
            end
        end
    end

endmodule

// File: rtl/rst_req_sequencer.sv
// Serialises reset requests into the reset block's auxiliary input and tracks
// peripheral_aresetn through assertion and release, with per-phase timeouts.
module rst_req_sequencer
    import rst_seq_pkg::*;
#(
    parameter int C_NUM_REQ     = 4,
    parameter int C_PULSE_WIDTH = 16,
    parameter int C_TIMEOUT     = 64
) (
    input  logic                               slowest_sync_clk,
    input  logic                               ext_reset_in,
    input  logic [C_NUM_REQ-1:0]               req,
    output logic [C_NUM_REQ-1:0]               ack,
    output logic                               err,
    output logic [id_width(C_NUM_REQ)-1:0]     grant_id,
    output logic                               busy,
    output logic                               aux_reset_out,
    input  logic                               rst_status_n
);

    localparam int C_CNT_WIDTH = cnt_width(C_PULSE_WIDTH, C_TIMEOUT);
    localparam int GW          = id_width(C_NUM_REQ);

    localparam logic [C_CNT_WIDTH-1:0] PULSE_LAST   = C_CNT_WIDTH'(C_PULSE_WIDTH - 1);
    localparam logic [C_CNT_WIDTH-1:0] TIMEOUT_LAST = C_CNT_WIDTH'(C_TIMEOUT - 1);
    localparam logic [GW-1:0]          LAST_ID      = GW'(C_NUM_REQ - 1);

    state_t                 state;
    logic [C_CNT_WIDTH-1:0] cnt;
    logic [GW-1:0]          ptr;
    logic                   arb_valid;
    logic [GW-1:0]          arb_idx;

    rr_arbiter #(
        .N (C_NUM_REQ),
        .W (GW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    // ack is raised on the edge that enters DONE so it lines up with err.
    // NOTE: all state here is sequential and uses non-blocking assignments only.
    always_ff @(posedge slowest_sync_clk) begin
        if (!ext_reset_in) begin
            state         <= ST_IDLE;
            ack           <= '0;
            err           <= 1'b0;
            grant_id      <= '0;
            busy          <= 1'b0;
            aux_reset_out <= 1'b1;
            ptr           <= '0;
            cnt           <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_id      <= arb_idx;
                        aux_reset_out <= 1'b0;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        state         <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (cnt == PULSE_LAST) begin
                        aux_reset_out <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_WAIT_LOW;
                    end else begin
                        cnt <= cnt + C_CNT_WIDTH'(1);
                    end
                end
                ST_WAIT_LOW: begin
                    if (!rst_status_n) begin
                        cnt   <= '0;
                        state <= ST_WAIT_HIGH;
                    end else if (cnt == TIMEOUT_LAST) begin
                        err   <= 1'b1;
                        ack   <= C_NUM_REQ'(1) << grant_id;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + C_CNT_WIDTH'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // Release seen on the final allowed cycle still counts as success.
                    if (rst_status_n) begin
                        err   <= 1'b0;
                        ack   <= C_NUM_REQ'(1) << grant_id;
                        state <= ST_DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        err   <= 1'b1;
                        ack   <= C_NUM_REQ'(1) << grant_id;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + C_CNT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    ptr   <= (grant_id == LAST_ID) ? '0 : grant_id + GW'(1);
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state         <= ST_IDLE;
                    busy          <= 1'b0;
                    aux_reset_out <= 1'b1;
                end
            endcase
        end
    end

endmodule
